// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream synchronous FIFO and sends
// each as start / data LSB-first / optional even parity / stop.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               parity_q, parity_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               rd_en_q, rd_en_d;
  logic               done_q, done_d;
  logic               baud_end;

  assign baud_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    if (state_q inside {START, DATA, PARITY, STOP})
      baud_d = baud_end ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE:   if (!fifo_empty) state_d = FETCH;
      FETCH:  state_d = LOAD;
      LOAD: begin
        shift_d  = fifo_rd_data;
        parity_d = ^fifo_rd_data;
        bit_d    = '0;
        state_d  = START;
      end
      START:  if (baud_end) state_d = DATA;
      DATA: begin
        if (baud_end) begin
          if (bit_q == BIT_W'(WIDTH - 1)) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      PARITY: if (baud_end) state_d = STOP;
      STOP:   if (baud_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) baud_d = '0;

    // Outputs are registered from the next state so they line up with it.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
    busy_d  = (state_d != IDLE);
    rd_en_d = (state_d == FETCH);
    done_d  = (state_q == STOP) && (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      rd_en_q  <= rd_en_d;
      done_q   <= done_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance without parity, one with,
// each fed by a small FIFO model and watched by a frame deserialiser.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- instance A: no parity ----------------
  logic       a_empty = 1'b1, a_rd_en, a_tx, a_busy, a_done, a_err = 1'b0;
  logic [7:0] a_rd_data = '0;
  logic [7:0] a_q[$];
  int         a_rd_t[$], a_fall_t[$], a_done_t[$];
  logic [10:0] a_frames[$];

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_dut_a (
    .clk(clk), .rst(rst), .fifo_empty(a_empty), .fifo_rd_data(a_rd_data),
    .fifo_rd_en(a_rd_en), .tx(a_tx), .busy(a_busy), .frame_done(a_done)
  );

  // ---------------- instance B: even parity ----------------
  logic       b_empty = 1'b1, b_rd_en, b_tx, b_busy, b_done, b_err = 1'b0;
  logic [7:0] b_rd_data = '0;
  logic [7:0] b_q[$];
  int         b_rd_t[$], b_fall_t[$], b_done_t[$];
  logic [10:0] b_frames[$];

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_dut_b (
    .clk(clk), .rst(rst), .fifo_empty(b_empty), .fifo_rd_data(b_rd_data),
    .fifo_rd_en(b_rd_en), .tx(b_tx), .busy(b_busy), .frame_done(b_done)
  );

  // FIFO models: pop on a read strobe, data valid the following cycle.
  always @(posedge clk) begin
    if (a_rd_en) begin
      if (a_q.size() == 0) a_err <= 1'b1;
      else begin
        a_rd_data <= a_q.pop_front();
        a_empty   <= (a_q.size() == 0);
      end
    end
    if (b_rd_en) begin
      if (b_q.size() == 0) b_err <= 1'b1;
      else begin
        b_rd_data <= b_q.pop_front();
        b_empty   <= (b_q.size() == 0);
      end
    end
  end

  // Line monitors: sample mid-bit on the falling clock edge.
  logic        a_tx_prev = 1'b1, a_in = 1'b0, a_rd_prev = 1'b0;
  logic        b_tx_prev = 1'b1, b_in = 1'b0;
  int          a_t0, a_nb, b_t0, b_nb, a_rd_b2b = 0;
  logic [10:0] a_vec, b_vec;

  always @(negedge clk) begin
    if (a_rd_en) begin
      a_rd_t.push_back(cyc);
      if (a_rd_prev) a_rd_b2b++;
    end
    a_rd_prev = a_rd_en;
    if (a_done) a_done_t.push_back(cyc);
    if (rst) a_in = 1'b0;
    else if (!a_in && a_tx_prev && !a_tx) begin
      a_in = 1'b1; a_t0 = cyc; a_nb = 0; a_vec = '0;
      a_fall_t.push_back(cyc);
    end
    if (a_in && ((cyc - a_t0) % CPB) == 1) begin
      a_vec[a_nb] = a_tx;
      a_nb++;
      if (a_nb == 10) begin a_frames.push_back(a_vec); a_in = 1'b0; end
    end
    a_tx_prev = a_tx;

    if (b_rd_en) b_rd_t.push_back(cyc);
    if (b_done) b_done_t.push_back(cyc);
    if (rst) b_in = 1'b0;
    else if (!b_in && b_tx_prev && !b_tx) begin
      b_in = 1'b1; b_t0 = cyc; b_nb = 0; b_vec = '0;
      b_fall_t.push_back(cyc);
    end
    if (b_in && ((cyc - b_t0) % CPB) == 1) begin
      b_vec[b_nb] = b_tx;
      b_nb++;
      if (b_nb == 11) begin b_frames.push_back(b_vec); b_in = 1'b0; end
    end
    b_tx_prev = b_tx;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0: return a_frames.size();
      1: return a_done_t.size();
      2: return b_frames.size();
      3: return b_done_t.size();
      default: return a_fall_t.size();
    endcase
  endfunction

  task automatic wait_size(input int which, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (qsize(which) >= n) break;
      tick(1);
    end
  endtask

  function automatic logic [31:0] frame10(input logic [7:0] b);
    return 32'({1'b1, b, 1'b0});
  endfunction

  function automatic logic [31:0] frame11(input logic [7:0] b);
    return 32'({1'b1, ^b, b, 1'b0});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol, rd0, na, nf;

    // Reset with a non-empty FIFO: outputs must stay at reset values.
    a_q.push_back(8'hA5); a_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check($sformatf("reset_outs_%0d", i), {28'd0, a_tx, a_busy, a_rd_en, a_done}, 32'b1000);
    end
    rst = 1'b0;
    tick(1);
    check("rd_en_after_release", a_rd_en, 1);

    // Single byte 0xA5.
    wait_size(0, 1, 100);
    wait_size(1, 1, 20);
    tick(5);
    check("a5_frame", a_frames[0], frame10(8'hA5));
    check("a5_done_minus_fall", a_done_t[0] - a_fall_t[0], 40);
    check("a5_fall_minus_rd", a_fall_t[0] - a_rd_t[0], 2);
    check("a5_done_count", a_done_t.size(), 1);
    check("a5_rd_count", a_rd_t.size(), 1);

    // Empty FIFO: line stays idle, no reads.
    viol = 0;
    rd0  = a_rd_t.size();
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (a_tx !== 1'b1 || a_busy !== 1'b0) viol++;
    end
    check("empty_idle_violations", viol, 0);
    check("empty_rd_count", a_rd_t.size(), rd0);

    // Back-to-back words.
    a_q.push_back(8'h00); a_q.push_back(8'hFF); a_q.push_back(8'h3C); a_empty = 1'b0;
    wait_size(0, 4, 200);
    wait_size(1, 4, 20);
    tick(5);
    check("b2b_frame_00", a_frames[1], frame10(8'h00));
    check("b2b_frame_ff", a_frames[2], frame10(8'hFF));
    check("b2b_frame_3c", a_frames[3], frame10(8'h3C));
    check("b2b_period_1", a_fall_t[2] - a_fall_t[1], 43);
    check("b2b_period_2", a_fall_t[3] - a_fall_t[2], 43);
    check("b2b_rd_count", a_rd_t.size(), 4);
    check("b2b_done_count", a_done_t.size(), 4);
    check("b2b_read_error", a_err, 0);
    check("rd_en_consecutive", a_rd_b2b, 0);

    // Even parity on the second instance.
    b_q.push_back(8'h07); b_q.push_back(8'h03); b_empty = 1'b0;
    wait_size(2, 2, 200);
    wait_size(3, 2, 20);
    tick(5);
    check("par_frame_07", b_frames[0], frame11(8'h07));
    check("par_frame_03", b_frames[1], frame11(8'h03));
    check("par_bit_07", b_frames[0][9], 1);
    check("par_bit_03", b_frames[1][9], 0);
    check("par_frame_len", b_done_t[0] - b_fall_t[0], 44);
    check("par_read_error", b_err, 0);

    // Reset during data bit 3 of 0x96; 0x5A must follow intact.
    na = a_fall_t.size();
    a_q.push_back(8'h96); a_q.push_back(8'h5A); a_empty = 1'b0;
    wait_size(4, na + 1, 20);
    tick(16);
    rst = 1'b1;
    tick(1);
    check("midrst_outs", {30'd0, a_tx, a_busy}, 32'b10);
    rst = 1'b0;
    nf = a_frames.size();
    wait_size(0, nf + 1, 100);
    tick(100);
    check("midrst_frame_count", a_frames.size(), nf + 1);
    check("midrst_next_frame", a_frames[nf], frame10(8'h5A));
    check("midrst_rd_count", a_rd_t.size(), 6);
    check("midrst_read_error", a_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
